// File: rtl/systolic_mm.sv
// Output-stationary N x N systolic array computing C = A*B for signed operands,
// with internal input skewing, valid/ready operand streaming and row-wise readout.
module systolic_mm #(
    parameter int N    = 4,
    parameter int DW   = 16,
    parameter int KMAX = 16,
    parameter int AW   = 2*DW + $clog2(KMAX)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [$clog2(KMAX):0]   k_len,
    input  logic [N*DW-1:0]         a_in,
    input  logic [N*DW-1:0]         b_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N*AW-1:0]         out_data,
    output logic [$clog2(N)-1:0]    out_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int KW = $clog2(KMAX) + 1;
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(KMAX + 2*N) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic          done_q, done_d;

    logic [KW-1:0] k_clamped;
    logic          job_start;
    logic          step;
    logic          feed_v;

    logic signed [DW-1:0] feed_a [N];
    logic signed [DW-1:0] feed_b [N];
    logic signed [DW-1:0] a_row  [N];
    logic signed [DW-1:0] b_col  [N];
    logic                 v_row  [N];

    logic signed [DW-1:0] a_q   [N][N-1];
    logic                 v_q   [N][N-1];
    logic signed [DW-1:0] b_q   [N-1][N];
    logic signed [AW-1:0] acc_q [N][N];

    assign k_clamped = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
    // A start coinciding with the done pulse is dropped so jobs never overlap.
    assign job_start = (state_q == S_IDLE) && start && !done_q;
    assign step      = ((state_q == S_LOAD) && in_valid) || (state_q == S_DRAIN);
    assign feed_v    = (state_q == S_LOAD);

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign out_row   = row_q;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            feed_a[i] = feed_v ? a_in[i*DW +: DW] : '0;
            feed_b[i] = feed_v ? b_in[i*DW +: DW] : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    k_d     = k_clamped;
                    cnt_d   = '0;
                    row_d   = '0;
                    state_d = (k_clamped == '0) ? S_OUT : S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (cnt_q == CW'(k_q) - CW'(1)) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(2*N-2)) begin
                    cnt_d   = '0;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (row_q == RW'(N-1)) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    // Row i of A and column i of B are delayed i steps; the valid tag travels with A.
    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_row[i] = feed_a[i];
            assign b_col[i] = feed_b[i];
            assign v_row[i] = feed_v;
        end else begin : g_chain
            logic signed [DW-1:0] sa_q [i];
            logic signed [DW-1:0] sb_q [i];
            logic                 sv_q [i];

            // NOTE: datapath registers are cleared on reset and on job start so an abandoned job leaves no residue.
            always_ff @(posedge clk) begin
                if (!rst || job_start) begin
                    for (int d = 0; d < i; d++) begin
                        sa_q[d] <= '0;
                        sb_q[d] <= '0;
                        sv_q[d] <= 1'b0;
                    end
                end else if (step) begin
                    sa_q[0] <= feed_a[i];
                    sb_q[0] <= feed_b[i];
                    sv_q[0] <= feed_v;
                    for (int d = 1; d < i; d++) begin
                        sa_q[d] <= sa_q[d-1];
                        sb_q[d] <= sb_q[d-1];
                        sv_q[d] <= sv_q[d-1];
                    end
                end
            end

            assign a_row[i] = sa_q[i-1];
            assign b_col[i] = sb_q[i-1];
            assign v_row[i] = sv_q[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_pe
            logic signed [DW-1:0]   a_left;
            logic signed [DW-1:0]   b_top;
            logic                   v_left;
            logic signed [2*DW-1:0] prod;

            if (j == 0) begin : g_a_edge
                assign a_left = a_row[i];
                assign v_left = v_row[i];
            end else begin : g_a_int
                assign a_left = a_q[i][j-1];
                assign v_left = v_q[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_top = b_col[j];
            end else begin : g_b_int
                assign b_top = b_q[i-1][j];
            end

            assign prod = a_left * b_top;

            if (j < N-1) begin : g_a_reg
                always_ff @(posedge clk) begin
                    if (!rst || job_start) begin
                        a_q[i][j] <= '0;
                        v_q[i][j] <= 1'b0;
                    end else if (step) begin
                        a_q[i][j] <= a_left;
                        v_q[i][j] <= v_left;
                    end
                end
            end

            if (i < N-1) begin : g_b_reg
                always_ff @(posedge clk) begin
                    if (!rst || job_start) begin
                        b_q[i][j] <= '0;
                    end else if (step) begin
                        b_q[i][j] <= b_top;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst || job_start) begin
                    acc_q[i][j] <= '0;
                end else if (step && v_left) begin
                    acc_q[i][j] <= acc_q[i][j] + {{(AW-2*DW){prod[2*DW-1]}}, prod};
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        if (state_q == S_OUT) begin
            for (int j = 0; j < N; j++) begin
                out_data[j*AW +: AW] = acc_q[row_q][j];
            end
        end
    end

endmodule

// File: tb/tb_systolic_mm.sv
// Directed self-checking bench for systolic_mm (N=4, DW=16, KMAX=16):
// identity, signed extremes, stalls, backpressure, K limits and mid-job reset.
module tb_systolic_mm;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int KMAX = 16;
    localparam int AW   = 2*DW + $clog2(KMAX);
    localparam int KW   = $clog2(KMAX) + 1;
    localparam int RW   = $clog2(N);
    localparam int MAXB = 20;
    localparam logic [7:0] STALL_PAT = 8'b0110_1001;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic [N*DW-1:0] a_in = '0;
    logic [N*DW-1:0] b_in = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*AW-1:0] out_data;
    logic [RW-1:0]   out_row;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            busy;
    logic            done;

    systolic_mm #(.N(N), .DW(DW), .KMAX(KMAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .a_in      (a_in),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic signed [DW-1:0] a_m [N][MAXB];
    logic signed [DW-1:0] b_m [MAXB][N];
    longint res [N][N];

    int beats, rows_seen, done_cnt, ready_cycles, last_beat_cyc, first_valid_cyc;
    bit order_ok, stable_ok, hold_seen, timeout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_identity();
        for (int k = 0; k < MAXB; k++) begin
            for (int i = 0; i < N; i++) a_m[i][k] = (i == k) ? 16'sd1 : 16'sd0;
            for (int j = 0; j < N; j++) b_m[k][j] = DW'(4*k + j + 1);
        end
    endtask

    task automatic set_const(input logic signed [DW-1:0] av, input logic signed [DW-1:0] bv);
        for (int k = 0; k < MAXB; k++) begin
            for (int i = 0; i < N; i++) a_m[i][k] = av;
            for (int j = 0; j < N; j++) b_m[k][j] = bv;
        end
    endtask

    // Drives one job from the start pulse through the done pulse; returns in the done cycle.
    task automatic run_job(input int k_req, input bit stall, input bit bp, input bit spurious);
        logic [7:0] pat;
        logic [N*AW-1:0] held_data;
        logic signed [AW-1:0] elem;
        int hold;
        int offer;
        pat = STALL_PAT;
        hold = 0;
        held_data = '0;
        offer = (k_req > MAXB) ? MAXB : k_req;
        beats = 0; rows_seen = 0; done_cnt = 0; ready_cycles = 0;
        last_beat_cyc = -1; first_valid_cyc = -1;
        order_ok = 1'b1; stable_ok = 1'b1; hold_seen = 1'b0; timeout = 1'b1;
        for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) res[r][j] = -1;

        start = 1'b1;
        k_len = KW'(k_req);
        tick();
        start = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (spurious && t == 2) begin
                start = 1'b1;
                k_len = KW'(1);
            end else begin
                start = 1'b0;
            end
            if (beats < offer) begin
                in_valid = stall ? pat[t % 8] : 1'b1;
                for (int i = 0; i < N; i++) a_in[i*DW +: DW] = a_m[i][beats];
                for (int j = 0; j < N; j++) b_in[j*DW +: DW] = b_m[beats][j];
            end else begin
                in_valid = 1'b0;
            end
            if (in_ready) ready_cycles++;

            out_ready = 1'b1;
            if (bp && out_valid && out_row == RW'(1)) begin
                if (hold == 0) held_data = out_data;
                else if (out_data !== held_data) stable_ok = 1'b0;
                if (hold < 3) begin
                    out_ready = 1'b0;
                    hold++;
                end
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = t;
            if (out_valid && out_ready) begin
                if (int'(out_row) != rows_seen) order_ok = 1'b0;
                for (int j = 0; j < N; j++) begin
                    elem = out_data[j*AW +: AW];
                    res[out_row][j] = elem;
                end
                rows_seen++;
            end
            if (in_valid && in_ready) begin
                beats++;
                last_beat_cyc = t;
            end
            if (done) begin
                done_cnt++;
                timeout = 1'b0;
                break;
            end
            tick();
        end
        hold_seen = (hold == 3);
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick(); tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset done got=%b exp=0", done); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset out_data got=%h exp=0", out_data); end
        checks++; if (out_row !== '0) begin failures++; $display("FAIL reset out_row got=%0d exp=0", out_row); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_identity();
        set_identity();
        run_job(4, 1'b0, 1'b0, 1'b0);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL identity timeout got=1 exp=0"); end
        checks++; if (beats != 4) begin failures++; $display("FAIL identity beats got=%0d exp=4", beats); end
        checks++; if (!order_ok || rows_seen != 4) begin failures++; $display("FAIL identity row_order rows=%0d exp=4 in order", rows_seen); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (res[r][j] !== longint'(4*r + j + 1)) begin
                    failures++;
                    $display("FAIL identity C[%0d][%0d] got=%0d exp=%0d", r, j, res[r][j], 4*r + j + 1);
                end
            end
        checks++; if (first_valid_cyc - last_beat_cyc != 2*N) begin failures++; $display("FAIL identity latency got=%0d exp=%0d", first_valid_cyc - last_beat_cyc, 2*N); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL identity done_count got=%0d exp=1", done_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL identity busy_at_done got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL identity out_valid_at_done got=%b exp=0", out_valid); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL identity done_width got=%b exp=0", done); end
    endtask

    task automatic test_signed_extreme();
        set_const(-16'sd32768, -16'sd32768);
        run_job(16, 1'b0, 1'b0, 1'b0);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL extreme_neg timeout got=1 exp=0"); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (res[r][j] !== 64'sd17179869184) begin
                    failures++;
                    $display("FAIL extreme_neg C[%0d][%0d] got=%0d exp=17179869184", r, j, res[r][j]);
                end
            end
        tick();
        set_const(-16'sd32768, 16'sd32767);
        run_job(16, 1'b0, 1'b0, 1'b0);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL extreme_mix timeout got=1 exp=0"); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (res[r][j] !== -64'sd17179344896) begin
                    failures++;
                    $display("FAIL extreme_mix C[%0d][%0d] got=%0d exp=-17179344896", r, j, res[r][j]);
                end
            end
        tick();
    endtask

    task automatic test_input_stalls();
        set_identity();
        run_job(4, 1'b1, 1'b0, 1'b0);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL stalls timeout got=1 exp=0"); end
        checks++; if (beats != 4) begin failures++; $display("FAIL stalls beats got=%0d exp=4", beats); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (res[r][j] !== longint'(4*r + j + 1)) begin
                    failures++;
                    $display("FAIL stalls C[%0d][%0d] got=%0d exp=%0d", r, j, res[r][j], 4*r + j + 1);
                end
            end
        tick();
    endtask

    task automatic test_backpressure();
        set_identity();
        run_job(4, 1'b0, 1'b1, 1'b0);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL backpressure timeout got=1 exp=0"); end
        checks++; if (hold_seen !== 1'b1) begin failures++; $display("FAIL backpressure hold got=%b exp=1", hold_seen); end
        checks++; if (stable_ok !== 1'b1) begin failures++; $display("FAIL backpressure stable got=%b exp=1", stable_ok); end
        checks++; if (!order_ok || rows_seen != 4) begin failures++; $display("FAIL backpressure row_order rows=%0d exp=4 in order", rows_seen); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (res[r][j] !== longint'(4*r + j + 1)) begin
                    failures++;
                    $display("FAIL backpressure C[%0d][%0d] got=%0d exp=%0d", r, j, res[r][j], 4*r + j + 1);
                end
            end
        tick();
    endtask

    task automatic test_k_boundaries();
        set_identity();
        run_job(0, 1'b0, 1'b0, 1'b0);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL k0 timeout got=1 exp=0"); end
        checks++; if (ready_cycles != 0) begin failures++; $display("FAIL k0 in_ready_cycles got=%0d exp=0", ready_cycles); end
        checks++; if (!order_ok || rows_seen != 4) begin failures++; $display("FAIL k0 rows got=%0d exp=4", rows_seen); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL k0 done_count got=%0d exp=1", done_cnt); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (res[r][j] !== 64'sd0) begin
                    failures++;
                    $display("FAIL k0 C[%0d][%0d] got=%0d exp=0", r, j, res[r][j]);
                end
            end
        tick();
        set_const(16'sd1, 16'sd1);
        run_job(20, 1'b0, 1'b0, 1'b0);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL k20 timeout got=1 exp=0"); end
        checks++; if (beats != 16) begin failures++; $display("FAIL k20 beats got=%0d exp=16", beats); end
        checks++; if (ready_cycles != 16) begin failures++; $display("FAIL k20 in_ready_cycles got=%0d exp=16", ready_cycles); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (res[r][j] !== 64'sd16) begin
                    failures++;
                    $display("FAIL k20 C[%0d][%0d] got=%0d exp=16", r, j, res[r][j]);
                end
            end
        tick();
    endtask

    task automatic test_reset_mid_load();
        set_const(16'sd7, -16'sd3);
        start = 1'b1;
        k_len = KW'(4);
        tick();
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            for (int i = 0; i < N; i++) a_in[i*DW +: DW] = a_m[i][b];
            for (int j = 0; j < N; j++) b_in[j*DW +: DW] = b_m[b][j];
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midreset in_ready got=%b exp=0", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset busy got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset out_valid got=%b exp=0", out_valid); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset done got=%b exp=0", done); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL midreset out_data got=%h exp=0", out_data); end
        checks++; if (out_row !== '0) begin failures++; $display("FAIL midreset out_row got=%0d exp=0", out_row); end
        tick();
        rst = 1'b1;
        tick();
        set_identity();
        run_job(4, 1'b0, 1'b0, 1'b1);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL midreset timeout got=1 exp=0"); end
        checks++; if (beats != 4) begin failures++; $display("FAIL midreset beats got=%0d exp=4", beats); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL midreset done_count got=%0d exp=1", done_cnt); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (res[r][j] !== longint'(4*r + j + 1)) begin
                    failures++;
                    $display("FAIL midreset C[%0d][%0d] got=%0d exp=%0d", r, j, res[r][j], 4*r + j + 1);
                end
            end
        tick();
    endtask

    task automatic test_back_to_back();
        set_identity();
        run_job(4, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        k_len = KW'(4);
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_at_done busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL start_at_done in_ready got=%b exp=0", in_ready); end
        set_const(-16'sd2, 16'sd5);
        run_job(3, 1'b0, 1'b0, 1'b0);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL back_to_back timeout got=1 exp=0"); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (res[r][j] !== -64'sd30) begin
                    failures++;
                    $display("FAIL back_to_back C[%0d][%0d] got=%0d exp=-30", r, j, res[r][j]);
                end
            end
        tick();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed_extreme();
        test_input_stalls();
        test_backpressure();
        test_k_boundaries();
        test_reset_mid_load();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_mm.md
# systolic_mm

Parametrised output-stationary systolic array computing C = A·B for signed fixed-point operands: A is N×K, B is K×N, C is N×N, with K set per job. It replaces the fixed 4-input systolic datapath with three generalisations: configurable array size and data width, internal input skewing, and valid/ready streaming on both the input and output sides. A job is started with `start`, operands are streamed one k-slice per beat, and C is read out one row per beat.

## Interface
- `N`, 4: array dimension (N×N PEs), 2..8.
- `DW`, 16: signed operand width.
- `KMAX`, 16: maximum inner dimension, power of two.
- `AW`, 2*DW+$clog2(KMAX): signed accumulator and output element width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle job request; sampled only in IDLE.
- `k_len`  in  $clog2(KMAX)+1  inner dimension K; sampled with `start`.
- `a_in`  in  N*DW  A column k; `a_in[i*DW +: DW]` = A[i][k].
- `b_in`  in  N*DW  B row k; `b_in[j*DW +: DW]` = B[k][j].
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  array accepts a beat.
- `out_data`  out  N*AW  C row r; `out_data[j*AW +: AW]` = C[r][j].
- `out_row`  out  $clog2(N)  index r of the presented row.
- `out_valid`  out  1  `out_data` holds a valid row.
- `out_ready`  in  1  consumer accepts the row.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last row is accepted.

## Operation
- FSM states: IDLE, LOAD, DRAIN, OUT.
- IDLE:
  - On `start`, latch K = min(`k_len`, KMAX).
  - Clear all accumulators, skew registers and PE pipeline registers.
  - Go to LOAD if K>0, otherwise go to OUT.
  - `start` is ignored in every other state.
- LOAD:
  - `in_ready` is 1.
  - A beat is accepted when `in_valid & in_ready`. Accepting a beat advances the array by one step.
  - If no beat is accepted, the whole array, including the skew registers, holds (a freeze, not a bubble).
  - After the K-th accepted beat, `in_ready` drops on the next cycle and the FSM goes to DRAIN.
- Skew: A row i is delayed i steps and B column j is delayed j steps, through register chains that are gated by the step enable.
- PE(i,j):
  - Passes a to the right and b downward through registers.
  - Holds a per-operand valid tag; zeros are injected during DRAIN with the tag cleared.
  - When the tag is set, acc += a*b using a full 2*DW signed product, sign-extended to AW.
  - AW is sized so that accumulation never overflows for K ≤ KMAX.
- DRAIN: the array steps unconditionally for 2N-1 cycles, then the FSM goes to OUT.
- OUT:
  - Rows r = 0..N-1 are presented in order. `out_valid` is 1 and `out_row` = r.
  - The row advances when `out_valid & out_ready`.
  - `out_data` and `out_row` are stable while `out_ready` is 0.
  - After row N-1 is accepted: `done` pulses for one cycle, `out_valid` drops, and the FSM returns to IDLE.
  - If K = 0, OUT presents N all-zero rows.
- Reset mid-job: the job is abandoned with no residue. The next job after `start` must be bit-exact.

## Timing
- Reset values: state IDLE; `in_ready`, `out_valid`, `busy`, `done` = 0; `out_data`, `out_row` = 0; all accumulators and pipeline registers = 0.
- `busy` rises the cycle after `start` is sampled and falls in the same cycle `done` pulses.
- `in_ready` is first high the cycle after `start`.
- If the last beat is accepted at step L, PE(i,j) accumulates beat k at step k+i+j.
- With no stalls, DRAIN occupies cycles L+1..L+2N-1, and the first `out_valid` occurs at cycle L+2N.
- Throughput with no stalls or backpressure: 1 + K + (2N-1) + N cycles per job, plus 1 IDLE cycle before the next `start` can be accepted.
- `done` and `start` never overlap. A `start` asserted in the cycle `done` pulses is ignored.

## Test plan
- Identity: N=4, K=4, A=I, B[k][j]=4k+j+1.
  - Rows out in order 0..3, with C=B (row 0 = 1,2,3,4).
  - First `out_valid` exactly 2N=8 cycles after the last beat.
  - `done` pulses once.
- Signed extreme: DW=16, K=16, all A and B elements = -32768.
  - Every C element = 2^34 with no wrap (AW=36).
  - Repeat with A = -32768 and B = 32767: every element = -17179344896.
- Input stalls: same operands as the identity test, with `in_valid` following the pattern 1,0,0,1,0,1,1,0…
  - C is identical to the no-stall run.
  - Exactly K beats are accepted.
- Output backpressure: `out_ready` held 0 for 3 cycles while row 1 is presented.
  - `out_data` and `out_row`=1 stay stable.
  - No row is skipped or duplicated.
- K boundaries:
  - `k_len`=0: no `in_ready` cycles, 4 zero rows, then `done`.
  - `k_len`=20: clamped to 16, `in_ready` accepts exactly 16 beats.
- Reset mid-LOAD: `rst`=0 after 2 beats.
  - Outputs return to their reset values.
  - A fresh identity job then gives the correct C.
  - A `start` issued while `busy` is ignored.
